game_interrupt_controller: RTL and testbench
============================================

// Module: game_interrupt_controller
// PURPOSE
//  Upstream of the title/game processors: produces INT_IRQ and KBD_KEY and runs the IACK/IEND handshake.
//  Merges a free-running frame tick (source 0) and keyboard make-codes (source 1) into one request line.
//  The frame tick has fixed priority over the keyboard.
//  Keyboard codes queue in a small FIFO so keys are not lost while a frame is being serviced.
// PARAMETERS
//  TICK_DIV    833333  CLK cycles per frame tick (60 Hz at 50 MHz); legal range 2..2^24-1
//  KFIFO_DEPTH 4       keyboard FIFO entries; must be a power of two, 2..16
// PORTS
//  CLK        in   1   clock; all logic on the rising edge
//  RESET      in   1   synchronous, active-high
//  INT_EN     in   2   per-source enable mask; bit0 = tick, bit1 = key; masked sources still set pending
//  KEY_VALID  in   1   one-cycle strobe; KEY_CODE is valid in that cycle
//  KEY_CODE   in   8   scancode from the keyboard receiver
//  INT_IRQ    out  2   0 = frame tick, 1 = key, 3 = no request; 2 is never driven
//  INT_IACK   in   1   one-cycle acknowledge from the processor
//  INT_IEND   in   1   one-cycle end-of-service from the processor
//  KBD_KEY    out  8   FIFO head; stable whenever INT_IRQ == 1
//  TICK_OVR   out  8   saturating count of ticks lost while one was already pending
//  KEY_OVR    out  8   saturating count of keys dropped because the FIFO was full
//  PROTO_ERR  out  1   sticky flag for a handshake violation
// BEHAVIOUR
//  Reset values: INT_IRQ = 3, KBD_KEY = 0, TICK_OVR = 0, KEY_OVR = 0, PROTO_ERR = 0.
//    Reset also clears the tick divider, both pending sources, the FIFO and the FSM (-> IDLE).
//    Reset takes effect in any state, including mid-service.
//  Tick divider
//    Counts 0..TICK_DIV-1 and asserts tick_pulse when it wraps to 0; never stops.
//    On tick_pulse: set tick_pend. If tick_pend is already set and is not being cleared
//      in the same cycle, increment TICK_OVR (saturates at 255).
//  Key FIFO (depth KFIFO_DEPTH)
//    KEY_VALID pushes KEY_CODE. If the FIFO is full, the code is dropped and KEY_OVR increments (saturates).
//    Push and pop in the same cycle while full: the pop frees a slot, so the push is accepted.
//    key_pend = FIFO not empty.
//    KBD_KEY shows the head; it shows 0 when empty.
//  FSM, 3 states
//    IDLE    INT_IRQ = 3.
//            Go to PRESENT(src) when (tick_pend & INT_EN[0]) or (key_pend & INT_EN[1]).
//            The tick wins if both qualify.
//            The source is latched in the transition cycle; INT_IRQ changes 1 cycle after the decision.
//    PRESENT INT_IRQ = latched src, held until INT_IACK. Not preempted.
//            A new tick does not replace a presented key.
//            On INT_IACK:
//              tick -> clear tick_pend
//              key  -> pop FIFO; KBD_KEY is still the presented code in the IACK cycle and advances next cycle
//            Then go to SERVICE.
//    SERVICE INT_IRQ = 3.
//            On INT_IEND go to IDLE; a new request can appear on INT_IRQ 2 cycles after IEND.
//  Simultaneous events
//    IACK and IEND in the same cycle in PRESENT: acknowledge, then go straight to IDLE.
//    tick_pulse in the same cycle as the tick IACK: the pend clear wins, then it is set again.
//      Net result: tick_pend = 1, TICK_OVR unchanged.
//  Protocol errors (set PROTO_ERR, otherwise ignored, no state change)
//    INT_IACK in IDLE or SERVICE.
//    INT_IEND in IDLE or PRESENT (except together with IACK in PRESENT).
//  Masking with INT_EN takes effect only in IDLE; a request already presented is not withdrawn.
// TESTING
//  1. TICK_DIV = 10, idle bus.
//     -> INT_IRQ 3->0 at cycle 11 after RESET falls.
//     -> IACK at cycle 13: INT_IRQ = 3 at cycle 14.
//     -> IEND at cycle 15: IDLE at 16.
//  2. Key 0x20 pushed while a tick is in SERVICE.
//     -> After IEND: INT_IRQ = 1 and KBD_KEY = 0x20.
//     -> IACK: FIFO becomes empty and KBD_KEY = 0 on the next cycle.
//  3. Tick and key pending together in IDLE.
//     -> INT_IRQ = 0 first.
//     -> After the tick IEND, INT_IRQ = 1 with the key still at the head.
//  4. Push 6 keys (0x11..0x16) with no service, KFIFO_DEPTH = 4.
//     -> KEY_OVR = 2.
//     -> Served in order 0x11, 0x12, 0x13, 0x14.
//  5. Hold off IACK for 3*TICK_DIV cycles.
//     -> TICK_OVR = 2.
//     -> Only one tick is presented.
//  6. IEND pulsed in IDLE, then RESET asserted mid-PRESENT.
//     -> PROTO_ERR = 1.
//     -> After reset: PROTO_ERR = 0, INT_IRQ = 3, FIFO empty.

Source files
------------

// File: rtl/game_interrupt_controller.sv
// Interrupt front end for the title/game processors.
// Merges a free-running frame tick (source 0) with keyboard make-codes
// (source 1) into one request line. The tick has fixed priority. Key codes
// wait in a small FIFO so none are lost while a frame is being serviced.
// The processor answers each request with an IACK/IEND handshake.
module game_interrupt_controller #(
   parameter int TICK_DIV    = 833333,
   parameter int KFIFO_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [1:0] INT_EN,
   input  logic       KEY_VALID,
   input  logic [7:0] KEY_CODE,
   output logic [1:0] INT_IRQ,
   input  logic       INT_IACK,
   input  logic       INT_IEND,
   output logic [7:0] KBD_KEY,
   output logic [7:0] TICK_OVR,
   output logic [7:0] KEY_OVR,
   output logic       PROTO_ERR
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW    = $clog2(KFIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             src;
   logic             src_next;

   logic [CNT_W-1:0] tick_cnt;
   logic             tick_pulse;
   logic             tick_pend;
   logic             key_pend;
   logic             ack_tick;
   logic             ack_key;
   logic             proto_viol;

   logic [7:0]       fifo_mem [KFIFO_DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push_ok;
   logic             key_drop;

   // Frame tick: the pulse is high in the last count so the wrap edge sets the pending bit
   always_comb begin
      tick_pulse = (tick_cnt == CNT_MAX);
   end

   // Free-running frame divider, wraps to zero every TICK_DIV cycles
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tick_cnt <= '0;
      end else if (tick_pulse) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Acknowledge decode and FIFO status; a push into a full FIFO is accepted when the head pops that cycle
   always_comb begin
      ack_tick   = (state == PRESENT) && INT_IACK && !src;
      ack_key    = (state == PRESENT) && INT_IACK && src;
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      key_pend   = !fifo_empty;
      push_ok    = KEY_VALID && (!fifo_full || ack_key);
      key_drop   = KEY_VALID && fifo_full && !ack_key;
      KBD_KEY    = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[AW-1:0]];
   end

   // Tick pending bit and lost-tick counter; a fresh tick re-sets the bit even as it is being acknowledged
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tick_pend <= 1'b0;
         TICK_OVR  <= 8'h00;
      end else begin
         if (tick_pulse) begin
            tick_pend <= 1'b1;
         end else if (ack_tick) begin
            tick_pend <= 1'b0;
         end
         if (tick_pulse && tick_pend && !ack_tick && (TICK_OVR != 8'hFF)) begin
            TICK_OVR <= TICK_OVR + 8'd1;
         end
      end
   end

   // Key FIFO storage; contents need no reset because the read side is gated by the pointers
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         fifo_mem[wr_ptr[AW-1:0]] <= KEY_CODE;
      end
   end

   // Key FIFO pointers and dropped-key counter
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         KEY_OVR <= 8'h00;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (ack_key && !fifo_empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (key_drop && (KEY_OVR != 8'hFF)) begin
            KEY_OVR <= KEY_OVR + 8'd1;
         end
      end
   end

   // Handshake FSM next state; enables are only consulted when choosing a new request in IDLE
   always_comb begin
      state_next = state;
      src_next   = src;
      proto_viol = 1'b0;
      case (state)
         IDLE: begin
            if (INT_IACK || INT_IEND) begin
               proto_viol = 1'b1;
            end
            if (tick_pend && INT_EN[0]) begin
               state_next = PRESENT;
               src_next   = 1'b0;
            end else if (key_pend && INT_EN[1]) begin
               state_next = PRESENT;
               src_next   = 1'b1;
            end
         end
         PRESENT: begin
            if (INT_IACK) begin
               state_next = INT_IEND ? IDLE : SERVICE;
            end else if (INT_IEND) begin
               proto_viol = 1'b1;
            end
         end
         SERVICE: begin
            if (INT_IACK) begin
               proto_viol = 1'b1;
            end
            if (INT_IEND) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Handshake FSM state, latched source and sticky protocol-error flag
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         src       <= 1'b0;
         PROTO_ERR <= 1'b0;
      end else begin
         state <= state_next;
         src   <= src_next;
         if (proto_viol) begin
            PROTO_ERR <= 1'b1;
         end
      end
   end

   // Request line shows the latched source only while presenting
   always_comb begin
      INT_IRQ = (state == PRESENT) ? {1'b0, src} : 2'd3;
   end

endmodule

// File: tb/tb_game_interrupt_controller.sv
// Directed self-checking bench for game_interrupt_controller.
// Runs with TICK_DIV = 10 and a 4-entry key FIFO. Cycle k is the interval
// after the k-th rising edge seen with RESET low; outputs are sampled 1 ns
// after the edge and inputs driven right after, so they apply during cycle k.
module tb_game_interrupt_controller;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [1:0] INT_EN = 2'b00;
   logic       KEY_VALID = 1'b0;
   logic [7:0] KEY_CODE = 8'h00;
   logic       INT_IACK = 1'b0;
   logic       INT_IEND = 1'b0;
   logic [1:0] INT_IRQ;
   logic [7:0] KBD_KEY;
   logic [7:0] TICK_OVR;
   logic [7:0] KEY_OVR;
   logic       PROTO_ERR;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   game_interrupt_controller #(
      .TICK_DIV    (10),
      .KFIFO_DEPTH (4)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .INT_EN    (INT_EN),
      .KEY_VALID (KEY_VALID),
      .KEY_CODE  (KEY_CODE),
      .INT_IRQ   (INT_IRQ),
      .INT_IACK  (INT_IACK),
      .INT_IEND  (INT_IEND),
      .KBD_KEY   (KBD_KEY),
      .TICK_OVR  (TICK_OVR),
      .KEY_OVR   (KEY_OVR),
      .PROTO_ERR (PROTO_ERR)
   );

   // 10 ns clock
   always #5 CLK = ~CLK;

   // Global time limit so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
         cyc++;
      end
   endtask

   task automatic goto_cycle(input int k);
      while (cyc < k) step(1);
   endtask

   task automatic do_reset(input logic [1:0] en);
      RESET     = 1'b1;
      INT_EN    = en;
      KEY_VALID = 1'b0;
      KEY_CODE  = 8'h00;
      INT_IACK  = 1'b0;
      INT_IEND  = 1'b0;
      step(3);
      RESET = 1'b0;
      cyc   = 0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      step(15);
      do_reset(2'b11);
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL reset_irq: got %0d expected 3", INT_IRQ); end
      checks++; if (KBD_KEY !== 8'h00) begin errors++; $display("[TB] FAIL reset_kbd: got %h expected 00", KBD_KEY); end
      checks++; if (TICK_OVR !== 8'h00) begin errors++; $display("[TB] FAIL reset_tickovr: got %0d expected 0", TICK_OVR); end
      checks++; if (KEY_OVR !== 8'h00) begin errors++; $display("[TB] FAIL reset_keyovr: got %0d expected 0", KEY_OVR); end
      checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto: got %b expected 0", PROTO_ERR); end
   endtask

   task automatic test_tick_basic();
      do_reset(2'b11);
      goto_cycle(10);
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL tick_c10: got %0d expected 3", INT_IRQ); end
      goto_cycle(11);
      checks++; if (INT_IRQ !== 2'd0) begin errors++; $display("[TB] FAIL tick_c11: got %0d expected 0", INT_IRQ); end
      goto_cycle(13);
      checks++; if (INT_IRQ !== 2'd0) begin errors++; $display("[TB] FAIL tick_held_c13: got %0d expected 0", INT_IRQ); end
      INT_IACK = 1'b1;
      goto_cycle(14);
      INT_IACK = 1'b0;
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL tick_ack_c14: got %0d expected 3", INT_IRQ); end
      goto_cycle(15);
      INT_IEND = 1'b1;
      goto_cycle(16);
      INT_IEND = 1'b0;
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL tick_end_c16: got %0d expected 3", INT_IRQ); end
      checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("[TB] FAIL tick_proto: got %b expected 0", PROTO_ERR); end
      goto_cycle(21);
      checks++; if (INT_IRQ !== 2'd0) begin errors++; $display("[TB] FAIL tick_second_c21: got %0d expected 0", INT_IRQ); end
   endtask

   task automatic test_key_during_service();
      do_reset(2'b11);
      goto_cycle(13);
      INT_IACK = 1'b1;
      goto_cycle(14);
      INT_IACK  = 1'b0;
      KEY_VALID = 1'b1;
      KEY_CODE  = 8'h20;
      goto_cycle(15);
      KEY_VALID = 1'b0;
      INT_IEND  = 1'b1;
      goto_cycle(16);
      INT_IEND = 1'b0;
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL key_idle_c16: got %0d expected 3", INT_IRQ); end
      goto_cycle(17);
      checks++; if (INT_IRQ !== 2'd1) begin errors++; $display("[TB] FAIL key_irq_c17: got %0d expected 1", INT_IRQ); end
      checks++; if (KBD_KEY !== 8'h20) begin errors++; $display("[TB] FAIL key_code_c17: got %h expected 20", KBD_KEY); end
      INT_IACK = 1'b1;
      goto_cycle(18);
      INT_IACK = 1'b0;
      checks++; if (KBD_KEY !== 8'h00) begin errors++; $display("[TB] FAIL key_popped: got %h expected 00", KBD_KEY); end
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL key_ack_irq: got %0d expected 3", INT_IRQ); end
      checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("[TB] FAIL key_proto: got %b expected 0", PROTO_ERR); end
   endtask

   task automatic test_priority();
      do_reset(2'b00);
      goto_cycle(2);
      KEY_VALID = 1'b1;
      KEY_CODE  = 8'h33;
      goto_cycle(3);
      KEY_VALID = 1'b0;
      goto_cycle(12);
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL prio_masked: got %0d expected 3", INT_IRQ); end
      INT_EN = 2'b11;
      goto_cycle(13);
      checks++; if (INT_IRQ !== 2'd0) begin errors++; $display("[TB] FAIL prio_tick_first: got %0d expected 0", INT_IRQ); end
      checks++; if (KBD_KEY !== 8'h33) begin errors++; $display("[TB] FAIL prio_head_kept: got %h expected 33", KBD_KEY); end
      INT_IACK = 1'b1;
      goto_cycle(14);
      INT_IACK = 1'b0;
      INT_IEND = 1'b1;
      goto_cycle(15);
      INT_IEND = 1'b0;
      goto_cycle(16);
      checks++; if (INT_IRQ !== 2'd1) begin errors++; $display("[TB] FAIL prio_key_next: got %0d expected 1", INT_IRQ); end
      checks++; if (KBD_KEY !== 8'h33) begin errors++; $display("[TB] FAIL prio_key_code: got %h expected 33", KBD_KEY); end
   endtask

   task automatic test_fifo_overflow();
      logic [7:0] order [4];
      int         n;
      order[0] = 8'h12; order[1] = 8'h13; order[2] = 8'h14; order[3] = 8'h77;
      do_reset(2'b10);
      goto_cycle(1);
      for (int i = 0; i < 6; i++) begin
         KEY_VALID = 1'b1;
         KEY_CODE  = 8'h11 + 8'(i);
         step(1);
      end
      KEY_VALID = 1'b0;
      step(1);
      checks++; if (KEY_OVR !== 8'd2) begin errors++; $display("[TB] FAIL fifo_keyovr: got %0d expected 2", KEY_OVR); end
      checks++; if (INT_IRQ !== 2'd1) begin errors++; $display("[TB] FAIL fifo_irq: got %0d expected 1", INT_IRQ); end
      checks++; if (KBD_KEY !== 8'h11) begin errors++; $display("[TB] FAIL fifo_first: got %h expected 11", KBD_KEY); end
      INT_IACK  = 1'b1;
      KEY_VALID = 1'b1;
      KEY_CODE  = 8'h77;
      step(1);
      INT_IACK  = 1'b0;
      KEY_VALID = 1'b0;
      checks++; if (KEY_OVR !== 8'd2) begin errors++; $display("[TB] FAIL fifo_full_pushpop: got %0d expected 2", KEY_OVR); end
      INT_IEND = 1'b1;
      step(1);
      INT_IEND = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (INT_IRQ !== 2'd1 && n < 10) begin
            step(1);
            n++;
         end
         checks++; if (INT_IRQ !== 2'd1) begin errors++; $display("[TB] FAIL fifo_present_%0d: got %0d expected 1", i, INT_IRQ); end
         checks++; if (KBD_KEY !== order[i]) begin errors++; $display("[TB] FAIL fifo_order_%0d: got %h expected %h", i, KBD_KEY, order[i]); end
         INT_IACK = 1'b1;
         step(1);
         INT_IACK = 1'b0;
         INT_IEND = 1'b1;
         step(1);
         INT_IEND = 1'b0;
      end
      step(3);
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL fifo_drained_irq: got %0d expected 3", INT_IRQ); end
      checks++; if (KBD_KEY !== 8'h00) begin errors++; $display("[TB] FAIL fifo_drained_kbd: got %h expected 00", KBD_KEY); end
   endtask

   task automatic test_tick_overrun();
      do_reset(2'b01);
      goto_cycle(11);
      checks++; if (INT_IRQ !== 2'd0) begin errors++; $display("[TB] FAIL ovr_present: got %0d expected 0", INT_IRQ); end
      goto_cycle(35);
      checks++; if (INT_IRQ !== 2'd0) begin errors++; $display("[TB] FAIL ovr_held: got %0d expected 0", INT_IRQ); end
      checks++; if (TICK_OVR !== 8'd2) begin errors++; $display("[TB] FAIL ovr_count: got %0d expected 2", TICK_OVR); end
      INT_IACK = 1'b1;
      goto_cycle(36);
      INT_IACK = 1'b0;
      INT_IEND = 1'b1;
      goto_cycle(37);
      INT_IEND = 1'b0;
      goto_cycle(39);
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL ovr_single: got %0d expected 3", INT_IRQ); end
      checks++; if (TICK_OVR !== 8'd2) begin errors++; $display("[TB] FAIL ovr_count_end: got %0d expected 2", TICK_OVR); end
   endtask

   task automatic test_back_to_back();
      do_reset(2'b01);
      goto_cycle(19);
      INT_IACK = 1'b1;
      INT_IEND = 1'b1;
      goto_cycle(20);
      INT_IACK = 1'b0;
      INT_IEND = 1'b0;
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL b2b_idle: got %0d expected 3", INT_IRQ); end
      checks++; if (TICK_OVR !== 8'd0) begin errors++; $display("[TB] FAIL b2b_tickovr: got %0d expected 0", TICK_OVR); end
      checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("[TB] FAIL b2b_proto: got %b expected 0", PROTO_ERR); end
      goto_cycle(21);
      checks++; if (INT_IRQ !== 2'd0) begin errors++; $display("[TB] FAIL b2b_repend: got %0d expected 0", INT_IRQ); end
   endtask

   task automatic test_proto_and_reset();
      do_reset(2'b00);
      goto_cycle(2);
      INT_IEND = 1'b1;
      goto_cycle(3);
      INT_IEND = 1'b0;
      checks++; if (PROTO_ERR !== 1'b1) begin errors++; $display("[TB] FAIL proto_iend_idle: got %b expected 1", PROTO_ERR); end
      KEY_VALID = 1'b1;
      KEY_CODE  = 8'h42;
      INT_EN    = 2'b10;
      goto_cycle(4);
      KEY_VALID = 1'b0;
      goto_cycle(5);
      checks++; if (INT_IRQ !== 2'd1) begin errors++; $display("[TB] FAIL proto_present: got %0d expected 1", INT_IRQ); end
      goto_cycle(6);
      RESET = 1'b1;
      goto_cycle(7);
      RESET = 1'b0;
      checks++; if (PROTO_ERR !== 1'b0) begin errors++; $display("[TB] FAIL midreset_proto: got %b expected 0", PROTO_ERR); end
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL midreset_irq: got %0d expected 3", INT_IRQ); end
      checks++; if (KBD_KEY !== 8'h00) begin errors++; $display("[TB] FAIL midreset_kbd: got %h expected 00", KBD_KEY); end
      goto_cycle(10);
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL midreset_empty: got %0d expected 3", INT_IRQ); end
      INT_IACK = 1'b1;
      goto_cycle(11);
      INT_IACK = 1'b0;
      checks++; if (PROTO_ERR !== 1'b1) begin errors++; $display("[TB] FAIL proto_iack_idle: got %b expected 1", PROTO_ERR); end
      checks++; if (INT_IRQ !== 2'd3) begin errors++; $display("[TB] FAIL proto_iack_irq: got %0d expected 3", INT_IRQ); end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_tick_basic();
      test_key_during_service();
      test_priority();
      test_fifo_overflow();
      test_tick_overrun();
      test_back_to_back();
      test_proto_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
